// File: rtl/cam_alloc.sv
// cam_alloc: entry allocator that sits in front of a CAM write port.
// It keeps the per-entry valid bitmap, gives each insert the lowest free
// address, frees entries on request, and evicts round-robin when full.
module cam_alloc #(
   parameter int DATA  = 16,
   parameter int DEPTH = 64,
   parameter bit EVICT = 1'b1,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ins_req,
   input  logic [DATA-1:0]   ins_data,
   output logic              ins_ready,
   output logic              ins_ack,
   output logic [ADDR-1:0]   ins_addr,
   output logic              ins_evict,
   input  logic              free_req,
   input  logic [ADDR-1:0]   free_addr,
   output logic              we_,
   output logic [DATA-1:0]   wd,
   output logic [DATA-1:0]   wm,
   output logic [ADDR-1:0]   waddr,
   output logic [DEPTH-1:0]  valid,
   output logic [ADDR:0]     count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR:0] DEPTH_CNT = (ADDR+1)'(DEPTH);

   // lowest index whose valid bit is clear; scanning downward lets the
   // lowest hit overwrite any higher one
   function automatic logic [ADDR-1:0] lowest_free(input logic [DEPTH-1:0] vec);
      logic [ADDR-1:0] idx;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!vec[i]) idx = ADDR'(i);
      end
      return idx;
   endfunction

   // count step: +1 for a fresh insert, -1 for an effective free, net 0 for both
   function automatic logic [ADDR:0] count_step(input logic [ADDR:0] cur,
                                                input logic inc,
                                                input logic dec);
      logic [ADDR:0] nxt;
      case ({inc, dec})
         2'b10:   nxt = cur + (ADDR+1)'(1);
         2'b01:   nxt = cur - (ADDR+1)'(1);
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   logic [DEPTH-1:0] valid_r;
   logic [ADDR:0]    count_r;
   logic [ADDR-1:0]  victim_r;

   logic             accept_p0;
   logic             evict_p0;
   logic [ADDR-1:0]  target_p0;
   logic             free_eff_p0;
   logic             free_lost_p0;
   logic [DEPTH-1:0] valid_nxt;
   logic [ADDR:0]    count_nxt;

   assign full      = (count_r == DEPTH_CNT);
   assign empty     = (count_r == '0);
   assign ins_ready = ~full | EVICT;
   assign valid     = valid_r;
   assign count     = count_r;
   assign wm        = '0;

   // request stage: decide acceptance, target entry and bitmap/count updates
   always_comb begin
      accept_p0    = ins_req & ins_ready;
      evict_p0     = accept_p0 & full;
      target_p0    = full ? victim_r : lowest_free(valid_r);
      free_eff_p0  = free_req & valid_r[free_addr];
      // an evicting insert onto the entry being freed keeps it valid
      free_lost_p0 = free_eff_p0 & accept_p0 & (target_p0 == free_addr);
      valid_nxt    = valid_r;
      if (free_eff_p0) valid_nxt[free_addr] = 1'b0;
      if (accept_p0)   valid_nxt[target_p0] = 1'b1;
      count_nxt    = count_step(count_r, accept_p0 & ~full,
                                free_eff_p0 & ~free_lost_p0);
   end

   // table state: valid bitmap, occupancy count and round-robin victim
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_r  <= '0;
         count_r  <= '0;
         victim_r <= '0;
      end else begin
         valid_r <= valid_nxt;
         count_r <= count_nxt;
         if (evict_p0) victim_r <= victim_r + 1'b1;
      end
   end

   // write stage: one-cycle registered CAM write strobe and insert acknowledge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_       <= 1'b1;
         wd        <= '0;
         waddr     <= '0;
         ins_ack   <= 1'b0;
         ins_addr  <= '0;
         ins_evict <= 1'b0;
      end else begin
         we_       <= ~accept_p0;
         ins_ack   <= accept_p0;
         ins_evict <= evict_p0;
         if (accept_p0) begin
            wd       <= ins_data;
            waddr    <= target_p0;
            ins_addr <= target_p0;
         end
      end
   end

endmodule
